// File: rtl/partial_sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// partial_sum_collector_pkg
//
// Shared definitions for the partial-sum collector that sits behind the CPE
// matrix accelerator.
//
// Contents:
//   psc_state_e - collector state machine encoding (IDLE, ACCUM, FINISH, PUSH)
//   acc_width() - internal accumulator width derived from data and pass widths
//   sat_max()   - largest signed value representable in data_width bits
//   sat_min()   - smallest signed value representable in data_width bits
//
// No ports: this is a package.
// -----------------------------------------------------------------------------
package partial_sum_collector_pkg;

   // Collector sequencing: wait for the first partial, gather the rest,
   // post-process for one cycle, then hand the result to the output FIFO.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2,
      PUSH   = 2'd3
   } psc_state_e;

   // One extra bit per doubling of the pass count, plus one for the bias, so
   // 2^pass_width full-scale partials plus the bias can never wrap.
   function automatic int acc_width(input int data_width, input int pass_width);
      return data_width + pass_width + 1;
   endfunction

   // Saturation bounds for a signed data_width-bit result. Returned as
   // longint so callers can resize them to whatever width they compare in.
   function automatic longint sat_max(input int data_width);
      return (longint'(1) <<< (data_width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int data_width);
      return -(longint'(1) <<< (data_width - 1));
   endfunction

endpackage

// File: rtl/partial_sum_collector_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Small first-word-fall-through FIFO with a synchronous, active-low reset.
// The head entry is always visible on rd_data while the FIFO is not empty.
// Written for the collector's output buffer but usable for any CPE output.
//
// Parameters:
//   DATA_WIDTH - entry width
//   DEPTH      - number of entries, power of 2, at least 2
//
// Ports:
//   Clk     in   clock, rising edge
//   Rst     in   synchronous reset, active-low
//   push    in   write wr_data (ignored while full)
//   wr_data in   entry to write
//   full    out  DEPTH entries held
//   pop     in   drop the head entry (ignored while empty)
//   rd_data out  head entry, 0 while empty
//   empty   out  no entries held
//   count   out  number of entries held, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   output logic                       full,
   input  logic                       pop,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int COUNT_W = ADDR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [COUNT_W-1:0]    count_q;
   logic                  do_push;
   logic                  do_pop;

   // A push into a full FIFO or a pop from an empty one is simply dropped;
   // a pop never makes room for a push in the same cycle because full is
   // based on the registered count.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (count_q == COUNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Storage needs no reset: an entry is only visible once written, and the
   // read port is forced to zero while nothing is held.
   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2; the count has
   // one extra bit so full and empty are never ambiguous.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + COUNT_W'(1);
            2'b01:   count_q <= count_q - COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Fall-through read of the head; zero when empty so the output word is
   // well defined straight out of reset.
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/partial_sum_collector.sv
// -----------------------------------------------------------------------------
// partial_sum_collector
//
// Downstream stage of the CPE matrix accelerator. Gathers a configured number
// of per-pass partial sums into one result, adds a bias, optionally clamps
// negative results to zero, saturates to DATA_WIDTH and buffers the result in
// a small FWFT FIFO with a valid/ready handshake toward writeback.
//
// Parameters:
//   DATA_WIDTH - partial sum / bias / result width, signed
//   PASS_WIDTH - width of the pass-count configuration
//   FIFO_DEPTH - result buffer entries, power of 2, at least 2
//
// Ports:
//   Clk             in   clock, rising edge
//   Rst             in   synchronous reset, active-low
//   cfgLoad         in   latch cfg* (only honoured in IDLE)
//   cfgPasses       in   partials per result, 0 behaves as 1
//   cfgBias         in   signed bias added once per result
//   cfgRelu         in   clamp negative results to 0
//   finalAccumulate in   signed partial sum from the accelerator
//   finalReady      in   level ready; a partial is taken on its rising edge
//   outData         out  FIFO head result
//   outValid        out  FIFO not empty
//   outReady        in   consumer takes the head when outValid is high
//   accBusy         out  a result is in progress
//   fifoFull        out  result buffer full
//   dropErr         out  sticky: a partial arrived while it could not be taken
//   passCount       out  partials gathered for the current result
// -----------------------------------------------------------------------------
module partial_sum_collector
   import partial_sum_collector_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PASS_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  cfgLoad,
   input  logic [PASS_WIDTH-1:0] cfgPasses,
   input  logic [DATA_WIDTH-1:0] cfgBias,
   input  logic                  cfgRelu,
   input  logic [DATA_WIDTH-1:0] finalAccumulate,
   input  logic                  finalReady,
   output logic [DATA_WIDTH-1:0] outData,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  accBusy,
   output logic                  fifoFull,
   output logic                  dropErr,
   output logic [PASS_WIDTH-1:0] passCount
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, PASS_WIDTH);
   localparam int COUNT_W   = $clog2(FIFO_DEPTH) + 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SAT_HI_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_LO_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   psc_state_e                   state_q;
   psc_state_e                   state_d;

   logic signed [ACC_WIDTH-1:0]  acc_q;
   logic [PASS_WIDTH-1:0]        pass_count_q;
   logic [PASS_WIDTH-1:0]        cfg_passes_q;
   logic [DATA_WIDTH-1:0]        cfg_bias_q;
   logic                         cfg_relu_q;
   logic                         ready_q;
   logic                         drop_err_q;
   logic [DATA_WIDTH-1:0]        res_q;

   logic                         rise;
   logic                         cfg_take;
   logic [PASS_WIDTH-1:0]        passes_raw;
   logic [PASS_WIDTH-1:0]        passes_eff;
   logic [PASS_WIDTH:0]          count_next;
   logic signed [ACC_WIDTH-1:0]  partial_ext;
   logic signed [ACC_WIDTH-1:0]  bias_ext;
   logic signed [ACC_WIDTH-1:0]  res_sum;
   logic signed [ACC_WIDTH-1:0]  res_relu;
   logic [DATA_WIDTH-1:0]        res_d;

   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_space;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [COUNT_W-1:0]           fifo_count;

   // The accelerator's ready is a level that can sit high for many cycles;
   // only its rising edge marks a new partial.
   assign rise = finalReady & ~ready_q;

   // Configuration loaded in the same cycle as the first capture applies to
   // that capture, so the pass count is taken straight from the inputs then.
   assign cfg_take   = (state_q == IDLE) & cfgLoad;
   assign passes_raw = cfg_take ? cfgPasses : cfg_passes_q;
   assign passes_eff = (passes_raw == '0) ? PASS_WIDTH'(1) : passes_raw;
   assign count_next = {1'b0, pass_count_q} + {{PASS_WIDTH{1'b0}}, 1'b1};

   assign partial_ext = {{(ACC_WIDTH-DATA_WIDTH){finalAccumulate[DATA_WIDTH-1]}}, finalAccumulate};
   assign bias_ext    = {{(ACC_WIDTH-DATA_WIDTH){cfg_bias_q[DATA_WIDTH-1]}}, cfg_bias_q};

   // Room in the buffer this cycle; a pop landing on the same edge does not
   // count, so a full buffer always costs at least one extra PUSH cycle.
   assign fifo_space = (fifo_count < COUNT_W'(FIFO_DEPTH));
   assign fifo_push  = (state_q == PUSH) & fifo_space;
   assign fifo_pop   = outValid & outReady;

   // Result post-processing: bias in full accumulator width, optional ReLU,
   // then clamp into the signed output range.
   always_comb begin
      res_sum  = acc_q + bias_ext;
      res_relu = (cfg_relu_q && (res_sum < 0)) ? '0 : res_sum;
      if (res_relu > SAT_HI) begin
         res_d = SAT_HI_D;
      end else if (res_relu < SAT_LO) begin
         res_d = SAT_LO_D;
      end else begin
         res_d = res_relu[DATA_WIDTH-1:0];
      end
   end

   // Next-state logic. The final partial moves straight to FINISH so the
   // result lands in the FIFO two edges after it is captured.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = (passes_eff == PASS_WIDTH'(1)) ? FINISH : ACCUM;
            end
         end
         ACCUM: begin
            if (rise && (count_next == {1'b0, passes_eff})) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = PUSH;
         end
         PUSH: begin
            if (fifo_space) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Edge detector history. It comes out of reset high so a ready level that
   // was already asserted during reset is not mistaken for a fresh partial.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         ready_q <= 1'b1;
      end else begin
         ready_q <= finalReady;
      end
   end

   // Configuration registers; frozen while a result is being gathered so a
   // mid-result load cannot change its pass count, bias or ReLU mode.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cfg_passes_q <= '0;
         cfg_bias_q   <= '0;
         cfg_relu_q   <= 1'b0;
      end else if (cfg_take) begin
         cfg_passes_q <= cfgPasses;
         cfg_bias_q   <= cfgBias;
         cfg_relu_q   <= cfgRelu;
      end
   end

   // Accumulation datapath. The first partial overwrites the accumulator so
   // nothing from the previous result needs clearing.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         acc_q        <= '0;
         pass_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  acc_q        <= partial_ext;
                  pass_count_q <= PASS_WIDTH'(1);
               end
            end
            ACCUM: begin
               if (rise) begin
                  acc_q        <= acc_q + partial_ext;
                  pass_count_q <= count_next[PASS_WIDTH-1:0];
               end
            end
            PUSH: begin
               if (fifo_space) begin
                  pass_count_q <= '0;
               end
            end
            default: begin
               pass_count_q <= pass_count_q;
            end
         endcase
      end
   end

   // The finished result is registered once in FINISH and held through any
   // backpressure in PUSH.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         res_q <= '0;
      end else if (state_q == FINISH) begin
         res_q <= res_d;
      end
   end

   // A partial arriving while the result is being finished or queued has
   // nowhere to go; flag it and keep the flag until reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         drop_err_q <= 1'b0;
      end else if (rise && ((state_q == FINISH) || (state_q == PUSH))) begin
         drop_err_q <= 1'b1;
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_result_fifo (
      .Clk     (Clk),
      .Rst     (Rst),
      .push    (fifo_push),
      .wr_data (res_q),
      .full    (fifo_full),
      .pop     (fifo_pop),
      .rd_data (outData),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign outValid  = ~fifo_empty;
   assign fifoFull  = fifo_full;
   assign accBusy   = (state_q != IDLE);
   assign dropErr   = drop_err_q;
   assign passCount = pass_count_q;

endmodule

// File: tb/tb_partial_sum_collector.sv
// -----------------------------------------------------------------------------
// tb_partial_sum_collector
//
// Self-checking bench for partial_sum_collector. Expected results come from a
// plain-arithmetic model: sum the partials as 64-bit integers, add the bias,
// clamp negatives when ReLU is on, then clip to the signed 32-bit range.
// -----------------------------------------------------------------------------
module tb_partial_sum_collector;

   localparam int DW = 32;
   localparam int PW = 8;
   localparam int FD = 4;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          cfgLoad = 1'b0;
   logic [PW-1:0] cfgPasses = '0;
   logic [DW-1:0] cfgBias = '0;
   logic          cfgRelu = 1'b0;
   logic [DW-1:0] finalAccumulate = '0;
   logic          finalReady = 1'b0;
   logic [DW-1:0] outData;
   logic          outValid;
   logic          outReady = 1'b0;
   logic          accBusy;
   logic          fifoFull;
   logic          dropErr;
   logic [PW-1:0] passCount;

   int vectors     = 0;
   int miscompares = 0;

   partial_sum_collector #(
      .DATA_WIDTH (DW),
      .PASS_WIDTH (PW),
      .FIFO_DEPTH (FD)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .cfgLoad         (cfgLoad),
      .cfgPasses       (cfgPasses),
      .cfgBias         (cfgBias),
      .cfgRelu         (cfgRelu),
      .finalAccumulate (finalAccumulate),
      .finalReady      (finalReady),
      .outData         (outData),
      .outValid        (outValid),
      .outReady        (outReady),
      .accBusy         (accBusy),
      .fifoFull        (fifoFull),
      .dropErr         (dropErr),
      .passCount       (passCount)
   );

   always #5 Clk = ~Clk;

   // Reference result: integer sum of partials plus bias, optional clamp to
   // zero, then clip into the signed 32-bit range.
   function automatic logic [31:0] model_result(input longint sum, input longint bias, input bit relu);
      longint r;
      r = sum + bias;
      if (relu && (r < 0)) r = 0;
      if (r > 64'sd2147483647) r = 64'sd2147483647;
      if (r < -64'sd2147483648) r = -64'sd2147483648;
      return r[31:0];
   endfunction

   task automatic load_cfg(input int passes, input logic [31:0] bias, input bit relu);
      @(negedge Clk);
      cfgLoad   = 1'b1;
      cfgPasses = passes[PW-1:0];
      cfgBias   = bias;
      cfgRelu   = relu;
      @(negedge Clk);
      cfgLoad   = 1'b0;
   endtask

   // One ready pulse carrying a partial, followed by enough quiet cycles for
   // a single-pass result to reach the buffer before the next pulse.
   task automatic pulse(input logic [31:0] v);
      @(negedge Clk);
      finalAccumulate = v;
      finalReady      = 1'b1;
      @(negedge Clk);
      finalReady      = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   // Wait (bounded) for a result at the head and pop it.
   task automatic collect(output logic [31:0] d, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      d  = '0;
      while (!ok && (n < 20)) begin
         @(negedge Clk);
         n++;
         if (outValid) begin
            d        = outData;
            outReady = 1'b1;
            @(negedge Clk);
            outReady = 1'b0;
            ok       = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      Rst        = 1'b0;
      finalReady = 1'b0;
      repeat (3) @(negedge Clk);
      vectors++;
      if ({outValid, fifoFull, accBusy, dropErr} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got valid/full/busy/drop=%b want 0000",
                  {outValid, fifoFull, accBusy, dropErr});
      end
      vectors++;
      if (passCount !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_passCount: got %0d want 0", passCount);
      end
      vectors++;
      if (outData !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outData: got %h want 0", outData);
      end
      Rst = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_sum_bias();
      logic [31:0] d;
      bit          ok;
      load_cfg(3, 32'd7, 1'b0);
      pulse(32'd10);
      vectors++;
      if ((passCount !== 8'd1) || (accBusy !== 1'b1)) begin
         miscompares++;
         $display("[TB] FAIL sum_pass1: got passCount=%0d busy=%b want 1 1", passCount, accBusy);
      end
      pulse(32'd20);
      vectors++;
      if (passCount !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL sum_pass2: got passCount=%0d want 2", passCount);
      end
      @(negedge Clk);
      finalAccumulate = -32'sd5;
      finalReady      = 1'b1;
      @(negedge Clk);
      finalReady      = 1'b0;
      vectors++;
      if ((passCount !== 8'd3) || (outValid !== 1'b0) || (accBusy !== 1'b1)) begin
         miscompares++;
         $display("[TB] FAIL sum_pass3: got passCount=%0d valid=%b busy=%b want 3 0 1",
                  passCount, outValid, accBusy);
      end
      @(negedge Clk);
      vectors++;
      if (outValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sum_latency_early: got valid=%b want 0", outValid);
      end
      @(negedge Clk);
      vectors++;
      if ((outValid !== 1'b1) || (outData !== 32'd32) || (passCount !== 8'd0)) begin
         miscompares++;
         $display("[TB] FAIL sum_latency: got valid=%b data=%0d passCount=%0d want 1 32 0",
                  outValid, outData, passCount);
      end
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'd32) || (outValid !== 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL sum_result: got %h ok=%b valid=%b want 00000020 1 0", d, ok, outValid);
      end
   endtask

   task automatic test_relu();
      logic [31:0] d;
      bit          ok;
      load_cfg(1, 32'd0, 1'b1);
      pulse(-32'sd100);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'h0000_0000)) begin
         miscompares++;
         $display("[TB] FAIL relu_on: got %h ok=%b want 00000000", d, ok);
      end
      load_cfg(1, 32'd0, 1'b0);
      pulse(-32'sd100);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'hFFFF_FF9C)) begin
         miscompares++;
         $display("[TB] FAIL relu_off: got %h ok=%b want ffffff9c", d, ok);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      bit          ok;
      load_cfg(2, 32'd0, 1'b0);
      pulse(32'h7FFF_FFF0);
      pulse(32'h7FFF_FFF0);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'h7FFF_FFFF)) begin
         miscompares++;
         $display("[TB] FAIL sat_hi: got %h ok=%b want 7fffffff", d, ok);
      end
      load_cfg(2, 32'hFFFF_FFFF, 1'b0);
      pulse(32'h8000_0000);
      pulse(32'h8000_0000);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'h8000_0000)) begin
         miscompares++;
         $display("[TB] FAIL sat_lo: got %h ok=%b want 80000000", d, ok);
      end
   endtask

   task automatic test_level_ready();
      logic [31:0] d;
      bit          ok;
      load_cfg(2, 32'd0, 1'b0);
      @(negedge Clk);
      finalAccumulate = 32'd5;
      finalReady      = 1'b1;
      repeat (6) begin
         @(negedge Clk);
         finalAccumulate = $urandom;
      end
      vectors++;
      if ((passCount !== 8'd1) || (accBusy !== 1'b1) || (outValid !== 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL level_single_capture: got passCount=%0d busy=%b valid=%b want 1 1 0",
                  passCount, accBusy, outValid);
      end
      finalReady = 1'b0;
      pulse(32'd9);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'd14) || (dropErr !== 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL level_result: got %h ok=%b drop=%b want 0000000e 1 0", d, ok, dropErr);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [31:0] v;
      logic [31:0] bias;
      bit          ok;
      bit          relu;
      int          passes;
      int          n;
      longint      sum;
      logic [31:0] expv;
      for (int r = 0; r < 24; r++) begin
         passes = $urandom_range(0, 5);
         bias   = $urandom;
         relu   = 1'($urandom_range(0, 1));
         load_cfg(passes, bias, relu);
         n   = (passes == 0) ? 1 : passes;
         sum = 0;
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       v = 32'h7FFF_FFFF;
               1:       v = 32'h8000_0000;
               default: v = $urandom;
            endcase
            sum += longint'($signed(v));
            pulse(v);
         end
         expv = model_result(sum, longint'($signed(bias)), relu);
         collect(d, ok);
         vectors++;
         if (!ok || (d !== expv)) begin
            miscompares++;
            $display("[TB] FAIL random_result[%0d]: got %h ok=%b want %h (passes=%0d relu=%b)",
                     r, d, ok, expv, passes, relu);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] vals [5];
      logic [31:0] d;
      bit          ok;
      outReady = 1'b0;
      load_cfg(1, 32'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         vals[i] = $urandom;
         pulse(vals[i]);
      end
      vectors++;
      if ((fifoFull !== 1'b1) || (accBusy !== 1'b1) || (outValid !== 1'b1) || (outData !== vals[0])) begin
         miscompares++;
         $display("[TB] FAIL bp_full: got full=%b busy=%b valid=%b head=%h want 1 1 1 %h",
                  fifoFull, accBusy, outValid, outData, vals[0]);
      end
      pulse(32'd123);
      vectors++;
      if ((dropErr !== 1'b1) || (accBusy !== 1'b1)) begin
         miscompares++;
         $display("[TB] FAIL bp_drop: got drop=%b busy=%b want 1 1", dropErr, accBusy);
      end
      for (int i = 0; i < 5; i++) begin
         collect(d, ok);
         vectors++;
         if (!ok || (d !== model_result(longint'($signed(vals[i])), 0, 1'b0))) begin
            miscompares++;
            $display("[TB] FAIL bp_drain[%0d]: got %h ok=%b want %h", i, d, ok, vals[i]);
         end
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if ((dropErr !== 1'b1) || (accBusy !== 1'b0) || (outValid !== 1'b0) || (fifoFull !== 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL bp_after: got drop=%b busy=%b valid=%b full=%b want 1 0 0 0",
                  dropErr, accBusy, outValid, fifoFull);
      end
   endtask

   task automatic test_reset_mid_accum();
      logic [31:0] d;
      bit          ok;
      load_cfg(3, 32'd0, 1'b0);
      pulse(32'd1);
      @(negedge Clk);
      finalAccumulate = 32'd2;
      finalReady      = 1'b1;
      @(negedge Clk);
      vectors++;
      if ((passCount !== 8'd2) || (accBusy !== 1'b1)) begin
         miscompares++;
         $display("[TB] FAIL mid_accum_pre: got passCount=%0d busy=%b want 2 1", passCount, accBusy);
      end
      Rst = 1'b0;
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      vectors++;
      if ({accBusy, outValid, dropErr} !== 3'b000 || (passCount !== 8'd0)) begin
         miscompares++;
         $display("[TB] FAIL mid_accum_reset: got busy/valid/drop=%b passCount=%0d want 000 0",
                  {accBusy, outValid, dropErr}, passCount);
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if ((passCount !== 8'd0) || (accBusy !== 1'b0)) begin
         miscompares++;
         $display("[TB] FAIL mid_accum_held_ready: got passCount=%0d busy=%b want 0 0", passCount, accBusy);
      end
      finalReady = 1'b0;
      pulse(32'd42);
      collect(d, ok);
      vectors++;
      if (!ok || (d !== 32'd42)) begin
         miscompares++;
         $display("[TB] FAIL mid_accum_recapture: got %h ok=%b want 0000002a", d, ok);
      end
   endtask

   initial begin
      test_reset();
      test_sum_bias();
      test_relu();
      test_saturation();
      test_level_ready();
      test_random();
      test_backpressure();
      test_reset_mid_accum();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/partial_sum_collector.md
Name: partial_sum_collector

Overview:
- Downstream stage of the CPE matrix accelerator. Consumes the accelerator's `finalAccumulate` / `finalReady` pair.
- Sums a configured number of per-pass partial results into one output value, for example across input channels.
- Adds a bias, applies optional ReLU, and saturates the result to `DATA_WIDTH`.
- Buffers finished results in a small FWFT FIFO with a valid/ready output handshake toward the writeback logic.

Parameters:
- DATA_WIDTH, 32, width of the partial sums, bias and output word (signed two's complement).
- PASS_WIDTH, 8, width of the pass-count configuration.
- FIFO_DEPTH, 4, number of result entries; must be a power of 2, at least 2.
- ACC_WIDTH, DATA_WIDTH+PASS_WIDTH+1, internal accumulator width; derived, do not override.

Ports:
- Clk  in  1  clock, all logic on rising edge.
- Rst  in  1  synchronous reset, active-low.
- cfgLoad  in  1  latch the cfg* inputs; honoured only in IDLE.
- cfgPasses  in  PASS_WIDTH  partials per result; 0 is treated as 1.
- cfgBias  in  DATA_WIDTH  signed bias added once per result.
- cfgRelu  in  1  1 = clamp negative results to 0.
- finalAccumulate  in  DATA_WIDTH  signed partial sum from the accelerator.
- finalReady  in  1  level ready from the accelerator; may stay high for many cycles.
- outData  out  DATA_WIDTH  FIFO head result.
- outValid  out  1  FIFO not empty.
- outReady  in  1  consumer accepts the head when outValid=1.
- accBusy  out  1  state != IDLE.
- fifoFull  out  1  FIFO holds FIFO_DEPTH entries.
- dropErr  out  1  sticky; a partial arrived while it could not be taken.
- passCount  out  PASS_WIDTH  partials accumulated for the current result.

Behaviour:
- Reset (Rst=0 at a clock edge) forces the following. Any result in progress is discarded.
  - Registers and outputs: state=IDLE, accumulator=0, passCount=0, dropErr=0, config regs=0 (passes read as 1).
  - FIFO: emptied, so outValid=0, fifoFull=0. outData=0.
  - finalReady_q is reset to 1, so a finalReady held high through reset is not captured as a new partial.
- Capture event: `rise = finalReady & ~finalReady_q`, with finalReady_q registered every cycle.
  - Exactly one partial is taken per rising edge, however long finalReady stays high.
- State machine:
  - IDLE:
    - cfgLoad latches the configuration.
    - On rise: acc <= sign-extended finalAccumulate, passCount <= 1.
    - Next state is FINISH if passes==1, else ACCUM.
    - cfgLoad and rise in the same cycle: the new config applies to this capture.
  - ACCUM:
    - On rise: acc <= acc + sign-extended finalAccumulate, passCount++.
    - Go to FINISH when passCount+1 == passes. cfgLoad is ignored.
  - FINISH (1 cycle):
    - res = acc + sign-extended bias, computed in ACC_WIDTH.
    - If cfgRelu and res<0, res=0.
    - Saturate res to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register it into resReg. Next state is PUSH.
  - PUSH:
    - If the FIFO is not full this cycle: write resReg, passCount <= 0, go to IDLE.
    - Otherwise stay in PUSH (backpressure). No bypass: a pop in the same cycle frees space only for the next cycle.
- A rise in FINISH or PUSH is not captured and sets dropErr. dropErr clears only on reset.
- Accumulator never wraps: ACC_WIDTH holds 2^PASS_WIDTH full-scale partials plus bias.
- Latency: final-pass rise seen at edge k. State FINISH after k, PUSH after k+1, FIFO written at k+2. outValid is high after edge k+2 if the FIFO was empty and not full.
- FIFO:
  - First-word-fall-through; outData is the head and is stable while outValid=1 and outReady=0.
  - Pop on outValid & outReady. Push and pop in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is kept in log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package: state enum (IDLE, ACCUM, FINISH, PUSH), the ACC_WIDTH derivation function, and the saturation min/max constants as functions of DATA_WIDTH.
- One sub-module: sync_fifo (params DATA_WIDTH, DEPTH; FWFT; full/empty/count; same Clk/Rst). It is reusable for other CPE output buffers.

Test Plan:
- Sum and bias: passes=3, bias=7, partials 10, 20, -5, each on a fresh rise → one output 32. outValid rises 3 cycles after the third rise; passCount runs 1, 2, 3.
- ReLU: passes=1, relu=1, bias=0, partial -100 → output 0. Same case with relu=0 → output -100 (0xFFFFFF9C).
- Saturation: passes=2, partials 0x7FFFFFF0 twice, bias 0 → 0x7FFFFFFF. Partials 0x80000000 twice with bias -1 → 0x80000000.
- Level ready: finalReady held high 6 cycles with passes=2 → only one partial captured, state stays ACCUM. A second pulse completes the result.
- Backpressure: outReady=0, passes=1, five results issued → four in FIFO, fifoFull=1, fifth held in PUSH with accBusy=1. A rise in PUSH sets dropErr=1. Then outReady=1 → outputs drain in order, fifth written, dropErr stays 1.
- Reset mid-ACCUM with finalReady held high across reset → after release: state IDLE, outValid=0, dropErr=0, no capture until finalReady falls and rises again.
